// File: rtl/vdma_frame_arbiter_if.sv
// AXI4-Stream video beat bundle shared by the two sources and the output of
// vdma_frame_arbiter. master drives the beat, slave drives tready.
interface vdma_frame_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 64
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tuser;
   logic                  tlast;

   modport master (
      output tdata,
      output tvalid,
      output tuser,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      input  tuser,
      input  tlast,
      output tready
   );
endinterface

// File: rtl/vdma_frame_arbiter.sv
// vdma_frame_arbiter: shares one AXI4-Stream video output between two sources with
// frame granularity. A source is granted on SOF (tuser), rows are counted by tlast, the
// output is released at end of frame and a programmable idle gap precedes the next grant.
// Beats arriving before a source's SOF are dropped to resynchronise that source.
module vdma_frame_arbiter #(
   parameter int unsigned DATA_WIDTH    = 64,
   parameter int unsigned ROW_CNT_WIDTH = 12,
   parameter int unsigned GAP_CNT_WIDTH = 16
) (
   input  logic                     s_axis_aclk,
   input  logic                     s_axis_aresetn,
   input  logic [ROW_CNT_WIDTH-1:0] cfg_vdma_row,
   input  logic [GAP_CNT_WIDTH-1:0] cfg_frame_gap,
   vdma_frame_arbiter_if.slave      s0_axis,
   vdma_frame_arbiter_if.slave      s1_axis,
   vdma_frame_arbiter_if.master     m_axis,
   output logic                     grant_id,
   output logic                     frame_done,
   output logic                     frame_err
);

   typedef enum logic [1:0] {StArb, StPass, StGap} state_e;

   state_e                   state_q;
   logic                     last_grant_q;
   logic                     first_beat_q;
   logic [ROW_CNT_WIDTH-1:0] row_cnt_q;
   logic [ROW_CNT_WIDTH-1:0] row_tgt_q;
   logic [GAP_CNT_WIDTH-1:0] gap_cnt_q;

   logic [DATA_WIDTH-1:0] m_tdata;
   logic                  m_tvalid;
   logic                  m_tuser;
   logic                  m_tlast;
   logic                  s0_tready;
   logic                  s1_tready;

   logic req0;
   logic req1;
   logic arb_valid;
   logic arb_grant;
   logic hs;

   // A source requests only while presenting its SOF beat.
   assign req0      = s0_axis.tvalid & s0_axis.tuser;
   assign req1      = s1_axis.tvalid & s1_axis.tuser;
   assign arb_valid = req0 | req1;
   // On a tie the source that did not win last time is granted.
   assign arb_grant = (req0 & req1) ? ~last_grant_q : req1;
   assign hs        = (state_q == StPass) & m_tvalid & m_axis.tready;

   assign m_axis.tdata  = m_tdata;
   assign m_axis.tvalid = m_tvalid;
   assign m_axis.tuser  = m_tuser;
   assign m_axis.tlast  = m_tlast;
   assign s0_axis.tready = s0_tready;
   assign s1_axis.tready = s1_tready;

   // Output mux and ready steering; everything is idle while reset is held.
   always_comb begin
      m_tdata   = '0;
      m_tvalid  = 1'b0;
      m_tuser   = 1'b0;
      m_tlast   = 1'b0;
      s0_tready = 1'b0;
      s1_tready = 1'b0;
      if (s_axis_aresetn) begin
         unique case (state_q)
            StArb: begin
               // Non-SOF beats are swallowed; SOF beats are held for the grant.
               s0_tready = s0_axis.tvalid & ~s0_axis.tuser;
               s1_tready = s1_axis.tvalid & ~s1_axis.tuser;
            end
            StPass: begin
               if (!grant_id) begin
                  m_tdata   = s0_axis.tdata;
                  m_tvalid  = s0_axis.tvalid;
                  m_tuser   = s0_axis.tuser;
                  m_tlast   = s0_axis.tlast;
                  s0_tready = m_axis.tready;
               end else begin
                  m_tdata   = s1_axis.tdata;
                  m_tvalid  = s1_axis.tvalid;
                  m_tuser   = s1_axis.tuser;
                  m_tlast   = s1_axis.tlast;
                  s1_tready = m_axis.tready;
               end
            end
            default: ;
         endcase
      end
   end

   // Frame scheduler: arbitration, row counting, gap timing and status pulses.
   always_ff @(posedge s_axis_aclk) begin
      if (!s_axis_aresetn) begin
         state_q      <= StArb;
         grant_id     <= 1'b0;
         last_grant_q <= 1'b1;
         first_beat_q <= 1'b0;
         row_cnt_q    <= '0;
         row_tgt_q    <= ROW_CNT_WIDTH'(1);
         gap_cnt_q    <= '0;
         frame_done   <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         unique case (state_q)
            StArb: begin
               if (arb_valid) begin
                  grant_id     <= arb_grant;
                  last_grant_q <= arb_grant;
                  row_tgt_q    <= (cfg_vdma_row == '0) ? ROW_CNT_WIDTH'(1) : cfg_vdma_row;
                  row_cnt_q    <= '0;
                  first_beat_q <= 1'b1;
                  state_q      <= StPass;
               end
            end
            StPass: begin
               if (hs) begin
                  first_beat_q <= 1'b0;
                  // A second SOF inside the frame is flagged but otherwise passed through.
                  if (m_tuser && !first_beat_q) begin
                     frame_err <= 1'b1;
                  end
                  if (m_tlast) begin
                     row_cnt_q <= row_cnt_q + ROW_CNT_WIDTH'(1);
                     if (row_cnt_q == row_tgt_q - ROW_CNT_WIDTH'(1)) begin
                        frame_done <= 1'b1;
                        gap_cnt_q  <= cfg_frame_gap;
                        state_q    <= (cfg_frame_gap == '0) ? StArb : StGap;
                     end
                  end
               end
            end
            StGap: begin
               gap_cnt_q <= gap_cnt_q - GAP_CNT_WIDTH'(1);
               if (gap_cnt_q <= GAP_CNT_WIDTH'(1)) begin
                  state_q <= StArb;
               end
            end
            default: state_q <= StArb;
         endcase
      end
   end

endmodule

// File: tb/tb_vdma_frame_arbiter.sv
// Scoreboard bench for vdma_frame_arbiter: frames are generated from the stream rules,
// expected output beats are queued at launch and a monitor checks every output handshake.
module tb_vdma_frame_arbiter;
   localparam int unsigned DW = 64;
   localparam int unsigned RW = 12;
   localparam int unsigned GW = 16;

   typedef struct {logic [63:0] data; bit user; bit last;} beat_t;
   typedef struct {
      logic [63:0] data; bit user; bit last; bit src; bit eof; bit err; int lat;
   } exp_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [RW-1:0] cfg_row = '0;
   logic [GW-1:0] cfg_gap = '0;
   logic          grant_id;
   logic          frame_done;
   logic          frame_err;

   vdma_frame_arbiter_if #(.DATA_WIDTH(DW)) s0_if ();
   vdma_frame_arbiter_if #(.DATA_WIDTH(DW)) s1_if ();
   vdma_frame_arbiter_if #(.DATA_WIDTH(DW)) m_if ();

   vdma_frame_arbiter #(
      .DATA_WIDTH   (DW),
      .ROW_CNT_WIDTH(RW),
      .GAP_CNT_WIDTH(GW)
   ) dut (
      .s_axis_aclk   (clk),
      .s_axis_aresetn(rstn),
      .cfg_vdma_row  (cfg_row),
      .cfg_frame_gap (cfg_gap),
      .s0_axis       (s0_if),
      .s1_axis       (s1_if),
      .m_axis        (m_if),
      .grant_id      (grant_id),
      .frame_done    (frame_done),
      .frame_err     (frame_err)
   );

   always #5 clk = ~clk;

   beat_t q0[$];
   beat_t q1[$];
   exp_t  sb[$];
   int    n_vec = 0;
   int    n_err = 0;
   int    cycle = 0;
   int    ref_cycle = 0;
   int    frame_no = 0;
   bit    last_grant_m = 1'b1;
   int    exp_done = 0, exp_errs = 0, got_done = 0, got_errs = 0;
   bit    done_pend = 1'b0, err_pend = 1'b0, lat_done = 1'b0;
   int    rdy_pct = 100;
   int    bubble_pct = 0;
   bit    flush = 1'b0;
   int    hs_cnt = 0;
   beat_t cur[2];
   bit    have[2];

   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Reference frame builder: rows = cfg (0 means 1), tlast every bpr beats, SOF on beat 0.
   function automatic void gen_frame(input bit src, input int rows_cfg, input int bpr,
                                     input int eb, input int lat);
      int rows;
      int n;
      beat_t b;
      exp_t e;
      rows = (rows_cfg == 0) ? 1 : rows_cfg;
      n = rows * bpr;
      for (int i = 0; i < n; i++) begin
         b.data = {8'(src), 24'(frame_no), 32'(i)};
         b.user = (i == 0) || (i == eb);
         b.last = (i % bpr) == bpr - 1;
         if (src) q1.push_back(b);
         else q0.push_back(b);
         e.data = b.data; e.user = b.user; e.last = b.last; e.src = src;
         e.eof = (i == n - 1);
         e.err = (i == eb) && (i != 0);
         e.lat = (i == 0) ? lat : -1;
         sb.push_back(e);
         if (e.err) exp_errs++;
      end
      exp_done++;
      frame_no++;
   endfunction

   function automatic void garbage(input bit src, input int n);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b.data = {$urandom, $urandom};
         b.user = 1'b0;
         b.last = ($urandom_range(1, 0) == 1);
         if (src) q1.push_back(b);
         else q0.push_back(b);
      end
   endfunction

   task automatic drive(input int id, input bit v, input beat_t b);
      if (id == 0) begin
         s0_if.tvalid = v; s0_if.tdata = v ? b.data : '0;
         s0_if.tuser = v & b.user; s0_if.tlast = v & b.last;
      end else begin
         s1_if.tvalid = v; s1_if.tdata = v ? b.data : '0;
         s1_if.tuser = v & b.user; s1_if.tlast = v & b.last;
      end
   endtask

   // Source drivers and output ready: change after the edge, note acceptance at negedge.
   initial begin
      s0_if.tvalid = 1'b0; s0_if.tdata = '0; s0_if.tuser = 1'b0; s0_if.tlast = 1'b0;
      s1_if.tvalid = 1'b0; s1_if.tdata = '0; s1_if.tuser = 1'b0; s1_if.tlast = 1'b0;
      m_if.tready = 1'b0;
      have[0] = 1'b0; have[1] = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (flush) begin
            q0.delete(); q1.delete();
            have[0] = 1'b0; have[1] = 1'b0;
            flush = 1'b0;
         end
         if (!have[0] && q0.size() > 0 &&
             (q0[0].user || $urandom_range(99, 0) >= bubble_pct)) begin
            cur[0] = q0.pop_front(); have[0] = 1'b1;
         end
         if (!have[1] && q1.size() > 0 &&
             (q1[0].user || $urandom_range(99, 0) >= bubble_pct)) begin
            cur[1] = q1.pop_front(); have[1] = 1'b1;
         end
         drive(0, have[0], cur[0]);
         drive(1, have[1], cur[1]);
         m_if.tready = ($urandom_range(99, 0) < rdy_pct);
         @(negedge clk);
         if (have[0] && s0_if.tready) have[0] = 1'b0;
         if (have[1] && s1_if.tready) have[1] = 1'b0;
      end
   end

   // Monitor: pops the scoreboard on each output handshake and checks status pulses.
   always @(negedge clk) begin
      exp_t e;
      if (rstn) begin
         if (done_pend || frame_done) chk("frame_done", frame_done, done_pend);
         if (err_pend || frame_err) chk("frame_err", frame_err, err_pend);
         if (frame_done) got_done++;
         if (frame_err) got_errs++;
         done_pend = 1'b0;
         err_pend = 1'b0;
         if (m_if.tvalid) begin
            if (sb.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_beat: got data %0h, expected no beat", m_if.tdata);
            end else begin
               if (sb[0].lat >= 0 && !lat_done) begin
                  chk("first_beat_latency", 64'(cycle - ref_cycle), 64'(sb[0].lat));
                  lat_done = 1'b1;
               end
               if (sb[0].src) begin
                  chk("ready_granted", s1_if.tready, m_if.tready);
                  chk("ready_other", s0_if.tready, 0);
               end else begin
                  chk("ready_granted", s0_if.tready, m_if.tready);
                  chk("ready_other", s1_if.tready, 0);
               end
               if (m_if.tready) begin
                  e = sb.pop_front();
                  lat_done = 1'b0;
                  hs_cnt++;
                  chk("tdata", m_if.tdata, e.data);
                  chk("tuser", m_if.tuser, e.user);
                  chk("tlast", m_if.tlast, e.last);
                  chk("grant_id", grant_id, e.src);
                  if (e.eof) begin
                     done_pend = 1'b1;
                     ref_cycle = cycle;
                  end
                  if (e.err) err_pend = 1'b1;
               end
            end
         end
      end
   end

   task automatic single(input bit src, input int rows, input int bpr, input int gap,
                         input int garb, input int eb);
      @(negedge clk);
      cfg_row = RW'(rows);
      cfg_gap = GW'(gap);
      garbage(src, garb);
      gen_frame(src, rows, bpr, eb, (garb == 0) ? 1 : -1);
      last_grant_m = src;
      ref_cycle = cycle + 1;
   endtask

   // Both sources raise SOF together; the loser is granted right after the gap.
   task automatic tie(input int rows, input int bpr, input int gap);
      bit first;
      @(negedge clk);
      cfg_row = RW'(rows);
      cfg_gap = GW'(gap);
      first = ~last_grant_m;
      gen_frame(first, rows, bpr, -1, 1);
      gen_frame(~first, rows, bpr, -1, gap + 2);
      last_grant_m = ~first;
      ref_cycle = cycle + 1;
   endtask

   task automatic wait_idle(input int gap);
      int t;
      t = 0;
      while ((sb.size() != 0 || q0.size() != 0 || q1.size() != 0) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 5000) begin
         n_vec++; n_err++;
         $display("FAIL drain_timeout: got %0d beats pending, expected 0", sb.size());
         sb.delete();
         flush = 1'b1;
      end
      repeat (gap + 4) @(negedge clk);
   endtask

   task automatic phase_end();
      chk("done_count", 64'(got_done), 64'(exp_done));
      chk("err_count", 64'(got_errs), 64'(exp_errs));
      got_done = 0; exp_done = 0; got_errs = 0; exp_errs = 0;
   endtask

   task automatic apply_reset(input int cycles);
      @(posedge clk);
      #2;
      rstn = 1'b0;
      flush = 1'b1;
      sb.delete();
      done_pend = 1'b0; err_pend = 1'b0; lat_done = 1'b0;
      @(negedge clk);
      chk("rst_m_tvalid", m_if.tvalid, 0);
      chk("rst_s0_tready", s0_if.tready, 0);
      chk("rst_s1_tready", s1_if.tready, 0);
      @(negedge clk);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_grant_id", grant_id, 0);
      repeat (cycles) @(negedge clk);
      @(posedge clk);
      #2;
      rstn = 1'b1;
      last_grant_m = 1'b1;
      got_done = 0; exp_done = 0; got_errs = 0; exp_errs = 0;
   endtask

   initial begin
      int base;
      int t;
      apply_reset(2);
      @(negedge clk);
      chk("idle_m_tvalid", m_if.tvalid, 0);
      chk("idle_m_tdata", m_if.tdata, 0);

      // Single source, 3x8 frame, gap 10.
      single(1'b0, 3, 8, 10, 0, -1);
      wait_idle(10);
      phase_end();

      // Simultaneous SOF, then again: round-robin order.
      tie(2, 4, 3);
      wait_idle(3);
      tie(2, 4, 0);
      wait_idle(0);
      phase_end();

      // Pre-SOF beats on s1 are dropped.
      single(1'b1, 2, 6, 4, 5, -1);
      wait_idle(4);
      phase_end();

      // Output back-pressure and source bubbles over a 4x16 frame.
      rdy_pct = 50; bubble_pct = 20;
      single(1'b0, 4, 16, 2, 0, -1);
      wait_idle(2);
      phase_end();

      // Mid-frame SOF on beat 5, then cfg_vdma_row=0 acting as one row.
      rdy_pct = 100; bubble_pct = 0;
      single(1'b0, 2, 8, 3, 0, 5);
      wait_idle(3);
      single(1'b1, 0, 5, 0, 0, -1);
      wait_idle(0);
      phase_end();

      // Randomised mix.
      for (int k = 0; k < 12; k++) begin
         int rows, bpr, gap, eb, n;
         rows = $urandom_range(3, 0);
         bpr = $urandom_range(6, 1);
         gap = $urandom_range(6, 0);
         rdy_pct = $urandom_range(100, 30);
         bubble_pct = $urandom_range(40, 0);
         n = ((rows == 0) ? 1 : rows) * bpr;
         eb = -1;
         if (n > 1 && $urandom_range(3, 0) == 0) eb = $urandom_range(n - 1, 1);
         if ($urandom_range(1, 0) == 1) tie(rows, bpr, gap);
         else single(1'($urandom_range(1, 0)), rows, bpr, gap, $urandom_range(3, 0), eb);
         wait_idle(gap);
         phase_end();
      end

      // Reset in the middle of row 1, then a tie must go to s0.
      rdy_pct = 100; bubble_pct = 0;
      single(1'b1, 3, 8, 5, 0, -1);
      base = hs_cnt;
      t = 0;
      while (hs_cnt < base + 10 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 1000) begin
         n_vec++; n_err++;
         $display("FAIL reset_setup_timeout: got %0d beats, expected 10", hs_cnt - base);
      end
      apply_reset(2);
      tie(1, 4, 2);
      wait_idle(2);
      phase_end();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/vdma_frame_arbiter.md
Name: vdma_frame_arbiter

Overview:
- Frame-granular scheduler that shares one AXI4-Stream video output between two mm2s video sources, for example two VDMA read channels feeding a single vdma_ctrl_v2 input.
- Grants the output to one source per frame, starting on tuser (SOF). It counts rows by tlast, releases at end of frame, and inserts a programmable idle gap before the next arbitration.
- Sources are resynchronised by dropping pre-SOF beats.

Parameters:
DATA_WIDTH, 64, tdata width of all streams
ROW_CNT_WIDTH, 12, width of row counter and cfg_vdma_row
GAP_CNT_WIDTH, 16, width of gap counter and cfg_frame_gap

Ports:
s_axis_aclk  in  1  single clock
s_axis_aresetn  in  1  synchronous active-low reset
cfg_vdma_row  in  ROW_CNT_WIDTH  rows (tlast count) per frame; 0 treated as 1
cfg_frame_gap  in  GAP_CNT_WIDTH  idle cycles inserted after each frame
s0_axis_tdata  in  DATA_WIDTH  source 0 data
s0_axis_tvalid  in  1  source 0 valid
s0_axis_tready  out  1  source 0 ready
s0_axis_tuser  in  1  source 0 SOF
s0_axis_tlast  in  1  source 0 end of line
s1_axis_tdata/tvalid/tready/tuser/tlast  same widths/directions as s0  source 1
m_axis_tdata  out  DATA_WIDTH  output data
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tuser  out  1  output SOF
m_axis_tlast  out  1  output end of line
grant_id  out  1  source currently or last granted
frame_done  out  1  one-cycle pulse at last beat of frame
frame_err  out  1  one-cycle pulse on tuser seen mid-frame

Behaviour:
- Reset (aresetn=0 at a clock edge) sets the following registers:
  - state=ARB, grant_id=0, last_grant=1 (so source 0 wins the first tie), row_cnt=0, gap_cnt=0.
  - frame_done=0, frame_err=0.
- Reset forces m_axis_tvalid=0 and s0/s1_axis_tready=0 from that cycle on.
- Reset mid-frame abandons the frame with no done/err pulse.
- States: ARB, PASS, GAP.

ARB:
- Source x has a request when sx_tvalid=1 and sx_tuser=1.
- A non-SOF beat (tvalid=1, tuser=0) gets sx_tready=1 and is discarded.
- A requesting source gets tready=0 and is not consumed in ARB.
- m_axis_tvalid=0.
- Exactly one request: grant it.
- Both requesting: grant the source != last_grant (round-robin).
- On grant: register grant_id and last_grant, latch cfg_vdma_row (0→1) into row_tgt, clear row_cnt, then go to PASS next cycle.
- No request: stay in ARB.
- Arbitration latency: SOF present in cycle N gives m_axis_tvalid with that SOF at N+1.

PASS:
- Zero-latency combinational mux of the granted source:
  - m_tdata/tuser/tlast/tvalid = sg_*.
  - sg_tready = m_axis_tready.
- The ungranted source has tready=0.
- Handshake = m_tvalid & m_tready.
- On a handshake with tlast=1, row_cnt increments.
- When that handshake is the one where row_cnt == row_tgt-1:
  - pulse frame_done the next cycle;
  - load gap_cnt=cfg_frame_gap;
  - go to GAP, or straight to ARB if cfg_frame_gap=0.
- A handshake with tuser=1 other than the first beat of the frame:
  - pulse frame_err;
  - the beat is still forwarded;
  - counters are unchanged.
- tvalid may drop mid-frame; the block waits with no timeout.
- cfg changes during PASS take effect only at the next grant.

GAP:
- All tready=0, m_axis_tvalid=0.
- gap_cnt decrements each cycle; at gap_cnt=1, go to ARB.
- A gap of G gives exactly G idle cycles between the frame's last handshake cycle and the first ARB cycle.

Outputs:
- In ARB and GAP, m_axis_tdata/tuser/tlast = 0.
- grant_id holds its value outside PASS.
- frame_done and frame_err are registered, one cycle wide, and never asserted in the same cycle as reset.
- row_cnt is compared at full ROW_CNT_WIDTH; no wrap within a frame because row_tgt ≤ 2^ROW_CNT_WIDTH-1.

Test Plan:
1. s0 only: 3 rows × 8 beats, SOF on beat 0, cfg_vdma_row=3, cfg_frame_gap=10, m_tready=1 → 24 beats out unchanged, first at SOF+1 cycle; frame_done pulse once; exactly 10 idle cycles; grant_id=0.
2. s0 and s1 assert SOF in the same cycle, twice in succession → first grant s0, second grant s1. The ungranted source's tready stays 0 throughout the other's frame.
3. s1 sends 5 non-SOF beats, then a 2-row frame with cfg_vdma_row=2 → the 5 beats are consumed (tready=1) and never appear on m_axis; the frame passes intact.
4. m_axis_tready toggles 1,0,0,1 pseudo-randomly during a 4×16 frame → 64 beats out, no duplication or loss; data matches an incrementing pattern; sg_tready mirrors m_tready.
5. tuser=1 on beat 5 of row 0 → frame_err pulses once, the beat is forwarded, and frame_done still fires after row_tgt rows; cfg_vdma_row=0 gives 1-row frames.
6. Reset asserted mid-row 1 → next cycle m_tvalid=0, tready=0, state ARB, no done pulse. After release, a new SOF is granted to s0 (tie-break) and the full frame passes.
